// File: rtl/uart_word_loader.sv
// uart_word_loader -- UART boot loader feeding a word-wide memory write port.
//
// After reset it sends HELLO_BYTE, receives a 4-byte little-endian byte count,
// then assembles WORD_BYTES-byte little-endian words and writes them to
// consecutive addresses.
// It answers DONE_BYTE on success or NAK_BYTE on any error, then holds status
// until restart.
//
// Optional feature macro: LOADER_CHECKSUM_EN. It adds one trailing byte that
// must equal the XOR of all payload bytes.
//
// Ports:
//   clk        system clock
//   rstn_uart  asynchronous active-low reset
//   rxd / txd  UART lines
//   restart    pulse, restarts the loader from DONE or ERROR only
//   mem_we     one-cycle write strobe with mem_addr / mem_wdata
//   loading    high while a load session is in progress
//   done / err final status, held until restart
//   word_count words expected (header / WORD_BYTES)
//
// Minimal uart_tx / uart_rx implementations live at the bottom of this file
// so the block elaborates on its own.

module uart_word_loader #(
    parameter int          CLK_PER_HALF_BIT = 217,
    parameter int          WORD_BYTES       = 4,
    parameter int          ADDR_WIDTH       = 14,
    parameter logic [7:0]  HELLO_BYTE       = 8'h99,
    parameter logic [7:0]  DONE_BYTE        = 8'hAA,
    parameter logic [7:0]  NAK_BYTE         = 8'h55
) (
    input  logic                    clk,
    input  logic                    rstn_uart,
    input  logic                    rxd,
    output logic                    txd,
    input  logic                    restart,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wdata,
    output logic                    loading,
    output logic                    done,
    output logic                    err,
    output logic [31:0]             word_count
);
    localparam int          DW        = 8 * WORD_BYTES;
    localparam int          IW        = (DW > 8) ? $clog2(DW) : 3;
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

    typedef enum logic [3:0] {
        S_HELLO, S_RX_HDR, S_CHECK, S_RX_WORD, S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_RX_SUM,
`endif
        S_RESULT, S_DONE, S_ERROR
    } state_t;

    state_t                  state_q;
    logic                    tx_phase_q;      // 0: request start, 1: wait for busy to drop
    logic                    tx_start_q;
    logic                    nak_q;
    logic                    rx_ready_prev_q;
    logic [2:0]              byte_cnt_q;
    logic [31:0]             header_q;
    logic [31:0]             word_count_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DW-1:0]           mem_wdata_q;
    logic                    mem_we_q, loading_q, done_q, err_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]              sum_q;
`endif

    logic       tx_busy, rx_ready, ferr;
    logic [7:0] rx_data, tx_sdata;
    logic       byte_acc, hdr_rem_bad, last_word;
    logic [31:0] hdr_words;

    // A byte counts only on the rising edge of rx_ready, so a level held
    // for several cycles is taken once.
    assign byte_acc    = rx_ready & ~rx_ready_prev_q;
    assign hdr_words   = header_q / 32'(WORD_BYTES);
    assign hdr_rem_bad = (header_q % 32'(WORD_BYTES)) != 32'd0;
    assign last_word   = (32'(mem_addr_q) + 32'd1) == word_count_q;
    assign tx_sdata    = (state_q == S_HELLO) ? HELLO_BYTE : (nak_q ? NAK_BYTE : DONE_BYTE);

    always_ff @(posedge clk or negedge rstn_uart) begin
        if (!rstn_uart) begin
            state_q         <= S_HELLO;
            tx_phase_q      <= 1'b0;
            tx_start_q      <= 1'b0;
            nak_q           <= 1'b0;
            rx_ready_prev_q <= 1'b0;
            byte_cnt_q      <= 3'd0;
            header_q        <= 32'd0;
            word_count_q    <= 32'd0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_we_q        <= 1'b0;
            loading_q       <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q           <= 8'd0;
`endif
        end else begin
            rx_ready_prev_q <= rx_ready;
            case (state_q)
                S_HELLO: begin
                    loading_q <= 1'b1;
                    if (!tx_phase_q) begin
                        tx_start_q <= ~tx_busy;
                        if (tx_busy) tx_phase_q <= 1'b1;
                    end else if (!tx_busy) begin
                        tx_phase_q <= 1'b0;
                        state_q    <= S_RX_HDR;
                        byte_cnt_q <= 3'd0;
                        header_q   <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
                        sum_q      <= 8'd0;
`endif
                    end
                end
                S_RX_HDR: if (byte_acc) begin
                    if (ferr) begin
                        nak_q   <= 1'b1;
                        state_q <= S_RESULT;
                    end else begin
                        header_q[{byte_cnt_q[1:0], 3'b000} +: 8] <= rx_data;
                        if (byte_cnt_q == 3'd3) begin
                            byte_cnt_q <= 3'd0;
                            state_q    <= S_CHECK;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 3'd1;
                        end
                    end
                end
                S_CHECK: begin
                    word_count_q <= hdr_words;
                    if (hdr_rem_bad || ({1'b0, hdr_words} > MAX_WORDS)) begin
                        nak_q   <= 1'b1;
                        state_q <= S_RESULT;
                    end else if (hdr_words == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q <= S_RX_SUM;
`else
                        state_q <= S_RESULT;
`endif
                    end else begin
                        byte_cnt_q <= 3'd0;
                        state_q    <= S_RX_WORD;
                    end
                end
                S_RX_WORD: if (byte_acc) begin
                    if (ferr) begin
                        nak_q   <= 1'b1;
                        state_q <= S_RESULT;
                    end else begin
                        mem_wdata_q[IW'({byte_cnt_q, 3'b000}) +: 8] <= rx_data;
`ifdef LOADER_CHECKSUM_EN
                        sum_q <= sum_q ^ rx_data;
`endif
                        if (byte_cnt_q == 3'(WORD_BYTES - 1)) begin
                            byte_cnt_q <= 3'd0;
                            mem_we_q   <= 1'b1;
                            state_q    <= S_WRITE;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 3'd1;
                        end
                    end
                end
                S_WRITE: begin
                    mem_we_q <= 1'b0;
                    // The address stays on the last written word once complete.
                    if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        state_q <= S_RX_SUM;
`else
                        state_q <= S_RESULT;
`endif
                    end else begin
                        mem_addr_q <= mem_addr_q + 1'b1;
                        state_q    <= S_RX_WORD;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_RX_SUM: if (byte_acc) begin
                    nak_q   <= ferr | (rx_data != sum_q);
                    state_q <= S_RESULT;
                end
`endif
                S_RESULT: begin
                    if (!tx_phase_q) begin
                        tx_start_q <= ~tx_busy;
                        if (tx_busy) tx_phase_q <= 1'b1;
                    end else if (!tx_busy) begin
                        tx_phase_q <= 1'b0;
                        loading_q  <= 1'b0;
                        done_q     <= ~nak_q;
                        err_q      <= nak_q;
                        state_q    <= nak_q ? S_ERROR : S_DONE;
                    end
                end
                S_DONE, S_ERROR: if (restart) begin
                    state_q      <= S_HELLO;
                    done_q       <= 1'b0;
                    err_q        <= 1'b0;
                    nak_q        <= 1'b0;
                    mem_addr_q   <= '0;
                    byte_cnt_q   <= 3'd0;
                    header_q     <= 32'd0;
                    word_count_q <= 32'd0;
                end
                default: state_q <= S_HELLO;
            endcase
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign loading    = loading_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = word_count_q;

    uart_tx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_tx (
        .clk(clk), .rst_n(rstn_uart), .sdata(tx_sdata), .tx_start(tx_start_q),
        .tx_busy(tx_busy), .txd(txd)
    );

    uart_rx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_rx (
        .clk(clk), .rst_n(rstn_uart), .rxd(rxd), .rx_data(rx_data),
        .rx_ready(rx_ready), .ferr(ferr)
    );
endmodule

// 8N1 transmitter: a frame starts when tx_start is seen while idle.
module uart_tx #(
    parameter int CLK_PER_HALF_BIT = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sdata,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       txd
);
    localparam int BIT = 2 * CLK_PER_HALF_BIT;
    localparam int CW  = $clog2(BIT) + 1;

    logic          busy_q;
    logic [9:0]    shift_q;
    logic [3:0]    bit_cnt_q;
    logic [CW-1:0] clk_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            shift_q   <= 10'h3FF;
            bit_cnt_q <= 4'd0;
            clk_cnt_q <= '0;
        end else if (!busy_q) begin
            if (tx_start) begin
                busy_q    <= 1'b1;
                shift_q   <= {1'b1, sdata, 1'b0};
                bit_cnt_q <= 4'd0;
                clk_cnt_q <= '0;
            end
        end else if (clk_cnt_q != CW'(BIT - 1)) begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
        end else begin
            clk_cnt_q <= '0;
            shift_q   <= {1'b1, shift_q[9:1]};
            if (bit_cnt_q == 4'd9) busy_q <= 1'b0;
            else bit_cnt_q <= bit_cnt_q + 4'd1;
        end
    end

    assign tx_busy = busy_q;
    assign txd     = busy_q ? shift_q[0] : 1'b1;
endmodule

// 8N1 receiver. rx_ready rises at the stop-bit sample and stays high until
// the next start bit; ferr reports a low stop bit for that byte.
module uart_rx #(
    parameter int CLK_PER_HALF_BIT = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       ferr
);
    localparam int BIT = 2 * CLK_PER_HALF_BIT;
    localparam int CW  = $clog2(BIT) + 1;

    logic          sync1_q, sync2_q, prev_q, active_q;
    logic [CW-1:0] clk_cnt_q, target;
    logic [3:0]    bit_cnt_q;
    logic [7:0]    shift_q;

    // Start bit is sampled mid-bit, every later bit one full period on.
    assign target = (bit_cnt_q == 4'd0) ? CW'(CLK_PER_HALF_BIT - 1) : CW'(BIT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            active_q  <= 1'b0;
            clk_cnt_q <= '0;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'd0;
            rx_data   <= 8'd0;
            rx_ready  <= 1'b0;
            ferr      <= 1'b0;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (!active_q) begin
                // Falling edge only: a line stuck low after a bad stop bit
                // does not retrigger.
                if (prev_q && !sync2_q) begin
                    active_q  <= 1'b1;
                    clk_cnt_q <= '0;
                    bit_cnt_q <= 4'd0;
                    rx_ready  <= 1'b0;
                end
            end else if (clk_cnt_q != target) begin
                clk_cnt_q <= clk_cnt_q + 1'b1;
            end else begin
                clk_cnt_q <= '0;
                if (bit_cnt_q == 4'd0) begin
                    if (sync2_q) active_q <= 1'b0;
                    else bit_cnt_q <= 4'd1;
                end else if (bit_cnt_q != 4'd9) begin
                    shift_q   <= {sync2_q, shift_q[7:1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end else begin
                    rx_data  <= shift_q;
                    ferr     <= ~sync2_q;
                    rx_ready <= 1'b1;
                    active_q <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_word_loader.sv
module tb_uart_word_loader;
    localparam int CPH  = 4;
    localparam int BIT  = 2 * CPH;
    localparam int WB   = 4;
    localparam int AW   = 3;
    localparam int MAXW = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn_uart = 1'b0;
    logic          rxd = 1'b1;
    logic          restart = 1'b0;
    logic          txd, mem_we, loading, done, err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   word_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]    tx_q[$];
    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];

    uart_word_loader #(
        .CLK_PER_HALF_BIT(CPH), .WORD_BYTES(WB), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rstn_uart(rstn_uart), .rxd(rxd), .txd(txd), .restart(restart),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .loading(loading), .done(done), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Decode every frame the loader transmits.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rstn_uart === 1'b1 && txd === 1'b0) begin
                repeat (BIT / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    b[i] = txd;
                end
                repeat (BIT) @(negedge clk);
                tx_q.push_back(b);
                $display("tx byte %h", b);
            end
        end
    end

    always @(negedge clk) begin
        if (rstn_uart === 1'b1 && mem_we === 1'b1) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            $display("write addr=%0d data=%h", mem_addr, mem_wdata);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = ~bad_stop;
        repeat (BIT) @(negedge clk);
        rxd = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic wait_tx(output logic [7:0] b, output bit got);
        int t = 0;
        got = 1'b0;
        b   = 8'h00;
        while (tx_q.size() == 0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (tx_q.size() != 0) begin
            b   = tx_q.pop_front();
            got = 1'b1;
        end
    endtask

    function automatic bit hdr_valid(input int unsigned hdr);
        return (hdr % WB == 0) && (hdr / WB <= MAXW);
    endfunction

    function automatic logic [7:0] xor_all(input logic [7:0] pl[$]);
        logic [7:0] x = 8'h00;
        foreach (pl[i]) x = x ^ pl[i];
        return x;
    endfunction

    // Header, then payload and (when enabled) checksum if the header is acceptable.
    task automatic drive_load(input int unsigned hdr, input logic [7:0] pl[$], input logic [7:0] cks);
        for (int i = 0; i < 4; i++) send_byte(8'((hdr >> (8 * i)) & 32'hFF), 1'b0);
        if (hdr_valid(hdr)) begin
            foreach (pl[i]) send_byte(pl[i], 1'b0);
`ifdef LOADER_CHECKSUM_EN
            send_byte(cks, 1'b0);
`else
            if (cks != cks) $display("unreachable");
`endif
        end
    endtask

    task automatic do_restart();
        logic [7:0] b;
        bit got;
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        wait_tx(b, got);
        n_cmp++;
        if (!got || b !== 8'h99) begin
            n_bad++;
            $display("FAIL restart_hello: got %h (received=%0d) want 99", b, got);
        end
        repeat (2 * BIT) @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || err !== 1'b0 || loading !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_status: done=%b err=%b loading=%b want 0 0 1", done, err, loading);
        end
        tx_q.delete();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic test_reset();
        logic [7:0] b;
        bit got;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (txd !== 1'b1 || loading !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0 ||
            err !== 1'b0 || mem_addr !== '0 || word_count !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_state: txd=%b loading=%b we=%b done=%b err=%b addr=%0d wc=%0d want 1 0 0 0 0 0 0",
                     txd, loading, mem_we, done, err, mem_addr, word_count);
        end
        rstn_uart = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (loading !== 1'b1 || mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: loading=%b we=%b want 1 0", loading, mem_we);
        end
        wait_tx(b, got);
        n_cmp++;
        if (!got || b !== 8'h99) begin
            n_bad++;
            $display("FAIL hello: got %h (received=%0d) want 99", b, got);
        end
        repeat (2 * BIT) @(negedge clk);
        tx_q.delete();
    endtask

    task automatic test_spec_vector();
        logic [7:0] b;
        bit got;
        logic [7:0] pl[$] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'd8 : 8'd0, 1'b0);
        // restart outside DONE/ERROR must not disturb the load
        @(negedge clk); restart = 1'b1; @(negedge clk); restart = 1'b0;
        foreach (pl[i]) send_byte(pl[i], 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h08, 1'b0);
`endif
        wait_tx(b, got);
        n_cmp++;
        if (!got || b !== 8'hAA) begin
            n_bad++;
            $display("FAIL spec_result: got %h (received=%0d) want aa", b, got);
        end
        repeat (2 * BIT) @(negedge clk);
        n_cmp++;
        if (wa_q.size() != 2 || wa_q[0] !== 3'd0 || wd_q[0] !== 32'h04030201 ||
            wa_q[1] !== 3'd1 || wd_q[1] !== 32'h08070605) begin
            n_bad++;
            $display("FAIL spec_writes: count=%0d first=%0d:%h want 2 writes 0:04030201 1:08070605",
                     wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : 3'd0, (wd_q.size() > 0) ? wd_q[0] : 32'd0);
        end
        n_cmp++;
        if (done !== 1'b1 || err !== 1'b0 || loading !== 1'b0 || word_count !== 32'd2 || mem_addr !== 3'd1) begin
            n_bad++;
            $display("FAIL spec_status: done=%b err=%b loading=%b wc=%0d addr=%0d want 1 0 0 2 1",
                     done, err, loading, word_count, mem_addr);
        end
        do_restart();
    endtask

    task automatic test_bad_len();
        logic [7:0] b;
        bit got;
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'd6 : 8'd0, 1'b0);
        wait_tx(b, got);
        n_cmp++;
        if (!got || b !== 8'h55) begin
            n_bad++;
            $display("FAIL badlen_result: got %h (received=%0d) want 55", b, got);
        end
        repeat (2 * BIT) @(negedge clk);
        n_cmp++;
        if (err !== 1'b1 || done !== 1'b0 || loading !== 1'b0 || wa_q.size() != 0) begin
            n_bad++;
            $display("FAIL badlen_status: err=%b done=%b loading=%b writes=%0d want 1 0 0 0",
                     err, done, loading, wa_q.size());
        end
        do_restart();
    endtask

    task automatic test_zero();
        logic [7:0] b;
        bit got;
        logic [7:0] pl[$];
        drive_load(0, pl, 8'h00);
        wait_tx(b, got);
        n_cmp++;
        if (!got || b !== 8'hAA) begin
            n_bad++;
            $display("FAIL zero_result: got %h (received=%0d) want aa", b, got);
        end
        repeat (2 * BIT) @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || err !== 1'b0 || wa_q.size() != 0 || word_count !== 32'd0) begin
            n_bad++;
            $display("FAIL zero_status: done=%b err=%b writes=%0d wc=%0d want 1 0 0 0",
                     done, err, wa_q.size(), word_count);
        end
        do_restart();
    endtask

    task automatic test_capacity();
        logic [7:0] b;
        bit got;
        logic [7:0] pl[$];
        drive_load(4 * (MAXW + 1), pl, 8'h00);
        wait_tx(b, got);
        n_cmp++;
        if (!got || b !== 8'h55) begin
            n_bad++;
            $display("FAIL over_capacity: got %h (received=%0d) want 55", b, got);
        end
        repeat (2 * BIT) @(negedge clk);
        do_restart();
        for (int i = 0; i < 4 * MAXW; i++) pl.push_back(8'($urandom_range(0, 255)));
        drive_load(4 * MAXW, pl, xor_all(pl));
        wait_tx(b, got);
        n_cmp++;
        if (!got || b !== 8'hAA) begin
            n_bad++;
            $display("FAIL full_capacity: got %h (received=%0d) want aa", b, got);
        end
        repeat (2 * BIT) @(negedge clk);
        n_cmp++;
        if (wa_q.size() != MAXW || mem_addr !== 3'(MAXW - 1) || word_count !== 32'(MAXW)) begin
            n_bad++;
            $display("FAIL full_status: writes=%0d addr=%0d wc=%0d want %0d %0d %0d",
                     wa_q.size(), mem_addr, word_count, MAXW, MAXW - 1, MAXW);
        end
        do_restart();
    endtask

    task automatic test_ferr();
        logic [7:0] b;
        bit got;
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'd8 : 8'd0, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        wait_tx(b, got);
        n_cmp++;
        if (!got || b !== 8'h55) begin
            n_bad++;
            $display("FAIL ferr_result: got %h (received=%0d) want 55", b, got);
        end
        send_byte(8'h33, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        n_cmp++;
        if (err !== 1'b1 || done !== 1'b0 || wa_q.size() != 0 || tx_q.size() != 0) begin
            n_bad++;
            $display("FAIL ferr_status: err=%b done=%b writes=%0d extra_tx=%0d want 1 0 0 0",
                     err, done, wa_q.size(), tx_q.size());
        end
        do_restart();
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            logic [7:0] b;
            bit got, ok;
            logic [7:0] pl[$];
            logic [7:0] cks;
            int unsigned words = $urandom_range(1, 4);
            int unsigned hdr   = words * WB;
            int unsigned kind  = $urandom_range(0, 4);
            if (kind == 0) hdr = hdr + $urandom_range(1, WB - 1);
            if (kind == 1) hdr = WB * $urandom_range(MAXW + 1, MAXW + 4);
            for (int i = 0; i < int'(words) * WB; i++) pl.push_back(8'($urandom_range(0, 255)));
            cks = xor_all(pl);
`ifdef LOADER_CHECKSUM_EN
            if ($urandom_range(0, 2) == 0) cks = cks ^ 8'(1 << $urandom_range(0, 7));
            ok = hdr_valid(hdr) && (cks == xor_all(pl));
`else
            ok = hdr_valid(hdr);
`endif
            drive_load(hdr, pl, cks);
            wait_tx(b, got);
            n_cmp++;
            if (!got || b !== (ok ? 8'hAA : 8'h55)) begin
                n_bad++;
                $display("FAIL rand%0d_result: got %h (received=%0d) want %h hdr=%0d",
                         it, b, got, ok ? 8'hAA : 8'h55, hdr);
            end
            repeat (2 * BIT) @(negedge clk);
            n_cmp++;
            if (done !== ok || err !== !ok || wa_q.size() != (hdr_valid(hdr) ? int'(words) : 0)) begin
                n_bad++;
                $display("FAIL rand%0d_status: done=%b err=%b writes=%0d want %b %b %0d",
                         it, done, err, wa_q.size(), ok, !ok, hdr_valid(hdr) ? words : 0);
            end
            if (hdr_valid(hdr)) begin
                for (int w = 0; w < int'(words) && w < wa_q.size(); w++) begin
                    logic [31:0] exp_word = 32'd0;
                    for (int k = 0; k < WB; k++) exp_word = exp_word + (32'(pl[w * WB + k]) << (8 * k));
                    n_cmp++;
                    if (wa_q[w] !== 3'(w) || wd_q[w] !== exp_word) begin
                        n_bad++;
                        $display("FAIL rand%0d_word%0d: got %0d:%h want %0d:%h",
                                 it, w, wa_q[w], wd_q[w], w, exp_word);
                    end
                end
                n_cmp++;
                if (word_count !== 32'(words)) begin
                    n_bad++;
                    $display("FAIL rand%0d_word_count: got %0d want %0d", it, word_count, words);
                end
            end
            do_restart();
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] b;
        bit got;
        logic [7:0] pl[$] = '{8'h01, 8'h02, 8'h03, 8'h04};
        drive_load(4, pl, 8'h04);
        wait_tx(b, got);
        n_cmp++;
        if (!got || b !== 8'hAA) begin
            n_bad++;
            $display("FAIL cks_good: got %h (received=%0d) want aa", b, got);
        end
        repeat (2 * BIT) @(negedge clk);
        do_restart();
        drive_load(4, pl, 8'h05);
        wait_tx(b, got);
        n_cmp++;
        if (!got || b !== 8'h55) begin
            n_bad++;
            $display("FAIL cks_bad: got %h (received=%0d) want 55", b, got);
        end
        repeat (2 * BIT) @(negedge clk);
        n_cmp++;
        if (err !== 1'b1 || done !== 1'b0 || wa_q.size() != 1) begin
            n_bad++;
            $display("FAIL cks_bad_status: err=%b done=%b writes=%0d want 1 0 1", err, done, wa_q.size());
        end
        do_restart();
    endtask
`endif

    task automatic test_reset_mid();
        logic [7:0] b;
        bit got;
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'd8 : 8'd0, 1'b0);
        send_byte(8'hA1, 1'b0);
        send_byte(8'hA2, 1'b0);
        @(negedge clk);
        #2 rstn_uart = 1'b0;
        #1;
        n_cmp++;
        if (loading !== 1'b0 || mem_we !== 1'b0 || txd !== 1'b1 || mem_addr !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: loading=%b we=%b txd=%b addr=%0d want 0 0 1 0",
                     loading, mem_we, txd, mem_addr);
        end
        repeat (4) @(negedge clk);
        tx_q.delete();
        rstn_uart = 1'b1;
        wait_tx(b, got);
        n_cmp++;
        if (!got || b !== 8'h99) begin
            n_bad++;
            $display("FAIL reset_mid_hello: got %h (received=%0d) want 99", b, got);
        end
    endtask

    initial begin
        test_reset();
        test_spec_vector();
        test_bad_len();
        test_zero();
        test_capacity();
        test_ferr();
        test_random();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_word_loader.md
# uart_word_loader

Parametrised UART boot loader for the core's instruction/data memory. After reset it announces itself with a hello byte, receives a 4-byte little-endian byte-count header, then streams words of WORD_BYTES bytes into a memory write port. It returns a completion or error byte over UART and holds status until restarted. It sits between the board UART pins and the program BRAM, ahead of core release from reset, and instantiates the existing uart_tx/uart_rx pair.

## Interface
- CLK_PER_HALF_BIT, 217, passed to uart_tx/uart_rx
- WORD_BYTES, 4, bytes per memory word (1..8)
- ADDR_WIDTH, 14, memory address width; capacity MAX_WORDS = 2**ADDR_WIDTH
- HELLO_BYTE, 8'h99, sent on start
- DONE_BYTE, 8'hAA, sent on successful load
- NAK_BYTE, 8'h55, sent on error

Ports:
- clk  in  1  system clock
- rstn_uart  in  1  reset, asynchronous, active-low
- rxd  in  1  UART receive line
- txd  out  1  UART transmit line
- restart  in  1  pulse; honoured only in DONE/ERROR
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  ADDR_WIDTH  word address
- mem_wdata  out  8*WORD_BYTES  assembled word
- loading  out  1  high from SEND_HELLO through SEND_RESULT
- done  out  1  high in DONE
- err  out  1  high in ERROR; sticky until restart/reset
- word_count  out  32  words expected (header / WORD_BYTES)

## Operation
- States: SEND_HELLO -> RX_HDR -> CHECK -> RX_WORD -> WRITE -> (RX_WORD | [RX_SUM] | SEND_RESULT) -> DONE or ERROR.
- Reset (async) forces SEND_HELLO; all outputs 0, counters 0, txd idle high (uart_tx reset).
- Byte acceptance: byte taken on the rising edge of rx_ready (registered previous rx_ready); a held-high rx_ready counts once.
- ferr high on an accepted byte -> ERROR path.
- RX_HDR: 4 bytes, first byte -> bits [7:0].
- CHECK (one cycle):
  - header mod WORD_BYTES != 0 -> ERROR path.
  - words > MAX_WORDS -> ERROR path.
  - words == 0 -> straight to SEND_RESULT with DONE_BYTE.
- RX_WORD: WORD_BYTES bytes little-endian into mem_wdata; byte k -> bits [8k+7:8k].
- WRITE: mem_we=1 for exactly one cycle with current mem_addr/mem_wdata, then mem_addr increments. After the final word, mem_addr stays at the last written address (no wrap to 0 when words == MAX_WORDS).
- ERROR path: send NAK_BYTE, enter ERROR. Later rx bytes are ignored.
- TX handshake: load sdata; assert tx_start until tx_busy seen high; deassert; wait tx_busy low; the state then advances.
- restart in DONE/ERROR: clear err/done/mem_addr/counters, go SEND_HELLO. restart in any other state is ignored.

## Timing
- mem_we asserts the cycle after the last byte of a word is accepted. Minimum spacing is one UART byte time, so no back-pressure.
- done/err rise the cycle after tx_busy falls for the result byte.
- loading falls in the same cycle that done/err rise.
- word_count is valid from the cycle after CHECK until restart.
- Async reset mid-transfer: outputs drop immediately; a partially written memory is not cleared.

## Configuration
- LOADER_CHECKSUM_EN defined: after the last word, RX_SUM accepts one extra byte. The expected value is the XOR of all payload bytes; the header is excluded. Match -> DONE_BYTE. Mismatch -> NAK_BYTE and ERROR. With zero words the expected byte is 8'h00 and is still received.
- Undefined: no RX_SUM state and no checksum logic; completion follows the last WRITE directly.

## Test plan
- Reset release -> txd frames 8'h99; loading=1, mem_we=0.
- Header 8,0,0,0 then bytes 01 02 03 04 05 06 07 08 (WORD_BYTES=4) -> writes addr0=32'h04030201 and addr1=32'h08070605; DONE_BYTE 8'hAA sent; done=1; word_count=2.
- Header 6,0,0,0 -> NAK 8'h55 sent, err=1, mem_we never pulses. restart -> 8'h99 resent and err clears.
- Header 0,0,0,0 -> immediate 8'hAA, no writes. With LOADER_CHECKSUM_EN, send 8'h00 first.
- Framing error injected on second payload byte -> one write max (none here), NAK sent, err=1. rx_ready held high for 3 cycles per byte -> each byte is counted once.
- LOADER_CHECKSUM_EN: payload 01 02 03 04, checksum 8'h04 -> 8'hAA. Same payload with checksum 8'h05 -> 8'h55 and err=1. Async reset asserted mid-word -> mem_we/loading drop the same cycle, then re-hello after release.
